// File: rtl/sram_b_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader: default widths and FSM encoding.
package sram_b_burst_reader_pkg;

  localparam int ABITS_DEF = 19;
  localparam int DBITS_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/sram_b_rd_fifo.sv
// Synchronous FIFO of {last, data}; registered pointers, combinational first-word read.
module sram_b_rd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[PW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/sram_b_burst_reader.sv
// Burst read front end: turns (base, length) descriptors into one SRAM read per cycle
// and returns the bytes as a valid/ready stream, issuing only against free FIFO credit.
module sram_b_burst_reader
  import sram_b_burst_reader_pkg::*;
#(
  parameter int ABITS      = ABITS_DEF,
  parameter int DBITS      = DBITS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [ABITS-1:0] req_len,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output state_t           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a producer holds valid and payload stable until that edge.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  state_t           next_state;
  logic [ABITS-1:0] cur_addr;
  logic [ABITS-1:0] remaining;
  logic [ABITS-1:0] a1_hold;
  logic             inflight;
  logic             inflight_last;
  logic             issue;
  logic             last_issue;
  logic [CW:0]      used;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [DBITS:0]   fifo_rd;
  logic             pop;

  // Credit includes the read in flight, so a pop only frees space one cycle later.
  assign used       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue      = (state == BURST) && (32'(used) < FIFO_DEPTH);
  assign last_issue = issue && (remaining == '0);

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = BURST;
      end
      BURST: begin
        if (last_issue) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      a1_hold       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= next_state;
      if (req_valid && req_ready) begin
        cur_addr  <= req_addr;
        remaining <= req_len;
      end
      if (issue) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
        a1_hold   <= cur_addr;
      end
      inflight      <= issue;
      inflight_last <= last_issue;
    end
  end

  assign CE1 = issue;
  assign A1  = issue ? cur_addr : a1_hold;

  sram_b_rd_fifo #(
    .W     (DBITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (inflight),
    .wr_data ({inflight_last, Q1}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_rd[DBITS-1:0] : '0;
  assign out_last  = out_valid && fifo_rd[DBITS];
  assign busy      = (state == BURST) || inflight || !fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// Scoreboard bench for sram_b_burst_reader with a behavioural SRAM and burst model.
module tb_sram_b_burst_reader;
  import sram_b_burst_reader_pkg::*;

  localparam int ABITS = 19;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [ABITS-1:0] req_addr = '0;
  logic [ABITS-1:0] req_len = '0;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DBITS-1:0] Q1 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DBITS-1:0] out_data;
  logic             out_last;
  logic             busy;
  state_t           fsm_state;

  sram_b_burst_reader #(.ABITS(ABITS), .DBITS(DBITS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .CE1(CE1), .A1(A1), .Q1(Q1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- SRAM model: contents are a fixed function of address, 1-cycle latency
  function automatic logic [DBITS-1:0] memf(input logic [ABITS-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ 8'h5A;
  endfunction

  always @(posedge CLK) Q1 <= CE1 ? memf(A1) : 8'($urandom);

  // ---------------- scoreboard state
  logic [DBITS:0]   exp_q[$];
  logic [ABITS-1:0] exp_a_q[$];
  int checks = 0;
  int passed = 0;
  int issue_cnt = 0;
  int last_cnt = 0;
  int last_ce_cyc = -1;
  int occ = 0;
  int hs_cyc = 0;
  bit held = 0;
  logic [DBITS:0] held_v = '0;
  bit rand_ready = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor
  always @(negedge CLK) begin
    logic [ABITS-1:0] ea;
    logic [DBITS:0]   ed;
    if (CE1) begin
      issue_cnt++;
      last_ce_cyc = cyc;
      occ++;
      if (exp_a_q.size() == 0) chk(1'b0, "a1_unexpected", 32'(A1), 32'hFFFFFFFF);
      else begin
        ea = exp_a_q.pop_front();
        chk(A1 == ea, "a1_addr", 32'(A1), 32'(ea));
      end
    end
    if (held && out_valid)
      chk({out_last, out_data} == held_v, "stall_stable", 32'({out_last, out_data}), 32'(held_v));
    held   = out_valid && !out_ready;
    held_v = {out_last, out_data};
    if (out_valid && out_ready) begin
      occ--;
      if (out_last) last_cnt++;
      if (exp_q.size() == 0) chk(1'b0, "beat_unexpected", 32'({out_last, out_data}), 32'hFFFFFFFF);
      else begin
        ed = exp_q.pop_front();
        chk({out_last, out_data} == ed, "beat", 32'({out_last, out_data}), 32'(ed));
      end
    end
    if (CE1) chk(occ <= DEPTH, "credit", 32'(occ), 32'(DEPTH));
  end

  always @(posedge CLK) if (rand_ready) #1 out_ready = 1'($urandom_range(0, 1));

  // ---------------- driver tasks (inputs change 1 time unit after the rising edge)
  task automatic send(input logic [ABITS-1:0] a, input logic [ABITS-1:0] l);
    bit ok = 0;
    logic [ABITS-1:0] ad;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1;
        hs_cyc = cyc;
      end
      @(posedge CLK);
    end
    chk(ok, "req_accept", 32'(ok), 32'd1);
    if (ok) begin
      for (int i = 0; i <= int'(l); i++) begin
        ad = a + ABITS'(i);
        exp_a_q.push_back(ad);
        exp_q.push_back({i == int'(l), memf(ad)});
      end
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (!busy && exp_q.size() == 0 && exp_a_q.size() == 0) done = 1;
    end
    chk(done, "drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(CE1 == 1'b0,       {tag, "_ce1"},       32'(CE1), 32'd0);
    chk(A1 == '0,          {tag, "_a1"},        32'(A1), 32'd0);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk(out_last == 1'b0,  {tag, "_out_last"},  32'(out_last), 32'd0);
    chk(out_data == '0,    {tag, "_out_data"},  32'(out_data), 32'd0);
    chk(busy == 1'b0,      {tag, "_busy"},      32'(busy), 32'd0);
    chk(req_ready == 1'b1, {tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk(fsm_state == IDLE, {tag, "_state"},     32'(fsm_state), 32'(IDLE));
  endtask

  // ---------------- main sequence
  initial begin
    int ce_c, ov_c, n, base, lc;
    bit done;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    // single beat: CE1 the cycle after handshake, out_valid two cycles after CE1
    out_ready = 1'b1;
    send(19'h00010, 19'd0);
    ce_c = -1;
    ov_c = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (CE1 && ce_c < 0) ce_c = cyc;
      if (out_valid && ov_c < 0) ov_c = cyc;
    end
    chk(ce_c == hs_cyc + 1, "single_ce1_cycle", 32'(ce_c), 32'(hs_cyc + 1));
    chk(ov_c - ce_c == 2, "single_latency", 32'(ov_c - ce_c), 32'd2);
    wait_idle();

    // streaming: 16 back-to-back reads with no credit stall
    send(19'h00100, 19'd15);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (CE1) n++;
    end
    chk(n == 16, "stream_ce1_run", 32'(n), 32'd16);
    @(negedge CLK);
    chk(CE1 == 1'b0, "stream_ce1_end", 32'(CE1), 32'd0);
    wait_idle();

    // backpressure: only FIFO_DEPTH reads may be outstanding
    out_ready = 1'b0;
    base = issue_cnt;
    send(19'h03000, 19'd31);
    repeat (12) @(posedge CLK);
    chk(issue_cnt - base == DEPTH, "bp_issue_count", 32'(issue_cnt - base), 32'(DEPTH));
    #1;
    chk(CE1 == 1'b0, "bp_ce1_stalled", 32'(CE1), 32'd0);
    done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(posedge CLK);
      #1 out_ready = !out_ready;
      if (!busy && exp_q.size() == 0) done = 1;
    end
    chk(done, "bp_drain", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;

    // address wrap at the top of the space
    send(19'h7FFFE, 19'd3);
    wait_idle();

    // back-to-back descriptors
    lc = last_cnt;
    send(19'h00500, 19'd7);
    send(19'h00600, 19'd5);
    chk(hs_cyc == last_ce_cyc + 1, "b2b_ready_after_last", 32'(hs_cyc), 32'(last_ce_cyc + 1));
    @(negedge CLK);
    chk(CE1 == 1'b1, "b2b_ce1_resume", 32'(CE1), 32'd1);
    wait_idle();
    chk(last_cnt - lc == 2, "b2b_last_count", 32'(last_cnt - lc), 32'd2);

    // reset in the middle of a burst
    base = issue_cnt;
    send(19'h02000, 19'd20);
    for (int c = 0; c < 50 && issue_cnt - base < 5; c++) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    exp_a_q.delete();
    occ = 0;
    held = 0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    @(posedge CLK);
    #1 RST = 1'b0;
    send(19'h02000, 19'd4);
    wait_idle();

    // randomized bursts with random consumer stalls
    rand_ready = 1;
    for (int b = 0; b < 12; b++) begin
      send(19'($urandom), 19'($urandom_range(0, 24)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rand_ready = 0;
    @(posedge CLK);
    #2 out_ready = 1'b1;

    chk(exp_q.size() == 0, "final_beats_left", 32'(exp_q.size()), 32'd0);
    chk(exp_a_q.size() == 0, "final_addrs_left", 32'(exp_a_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
